// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the multi-slot serial audio blocks.
// Imported by the transmitter and its frame timer (and a future receiver).
package i2s_pkg;

  localparam int I2S_MODE_PHILIPS   = 0;
  localparam int I2S_MODE_LEFT_JUST = 1;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int frame_cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_frame_timer.sv
// Free-running frame position counter with registered word select.
// The boundary strobe is high in the last bclk period of every frame.
module i2s_frame_timer
  import i2s_pkg::*;
#(
  parameter int SLOT_WIDTH = 32,
  parameter int NUM_SLOTS  = 2,
  localparam int FRAME     = SLOT_WIDTH * NUM_SLOTS,
  localparam int CW        = frame_cnt_width(FRAME)
) (
  input  logic          bclk,
  input  logic          rst,
  output logic [CW-1:0] cnt,
  output logic          lrclk,
  output logic          boundary
);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          lrclk_reg;

  assign boundary = (cnt_reg == CW'(FRAME - 1));
  assign cnt_next = boundary ? '0 : cnt_reg + CW'(1);

  // lrclk is registered from the next count so it changes with the counter.
  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= '0;
      lrclk_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      lrclk_reg <= (cnt_next >= CW'(FRAME / 2));
    end
  end

  assign cnt   = cnt_reg;
  assign lrclk = lrclk_reg;

endmodule

// File: rtl/i2s_tdm_tx.sv
// Multi-slot I2S / left-justified transmitter with a double-buffered frame store.
// Words are staged through valid/ready; a full stage is swapped in at each frame wrap.
module i2s_tdm_tx
  import i2s_pkg::*;
#(
  parameter int WORD_WIDTH      = 24,
  parameter int SLOT_WIDTH      = 32,
  parameter int NUM_SLOTS       = 2,
  parameter int MODE            = I2S_MODE_PHILIPS,
  parameter int UNDERRUN_REPEAT = 0,
  localparam int SIW            = $clog2(NUM_SLOTS)
) (
  input  logic                         bclk,
  input  logic                         rst,
  input  logic signed [WORD_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [SIW-1:0]               in_slot,
  output logic                         lrclk,
  output logic                         sdata,
  output logic                         frame_start,
  output logic                         underrun
);

  localparam int FRAME = SLOT_WIDTH * NUM_SLOTS;
  localparam int CW    = frame_cnt_width(FRAME);
  localparam int PW    = frame_cnt_width(SLOT_WIDTH);
  localparam int FW    = frame_cnt_width(NUM_SLOTS + 1);
  localparam int D     = (MODE == I2S_MODE_PHILIPS) ? 1 : 0;

  if (SLOT_WIDTH < WORD_WIDTH + D) begin : g_bad_slot_width
    $error("i2s_tdm_tx: SLOT_WIDTH cannot hold WORD_WIDTH plus the data delay");
  end
  if ((NUM_SLOTS < 2) || ((NUM_SLOTS % 2) != 0)) begin : g_bad_num_slots
    $error("i2s_tdm_tx: NUM_SLOTS must be even and at least 2");
  end
  if ((MODE != I2S_MODE_PHILIPS) && (MODE != I2S_MODE_LEFT_JUST)) begin : g_bad_mode
    $error("i2s_tdm_tx: MODE must be 0 (I2S) or 1 (left-justified)");
  end

  logic [CW-1:0]         frame_cnt;
  logic                  boundary;
  logic [CW-1:0]         cnt_adv;
  logic [SIW-1:0]        slot_adv;
  logic [PW-1:0]         pos_adv;
  logic [PW-1:0]         bit_off;
  logic                  in_window;

  logic [FW-1:0]         fill_reg;
  logic                  full;
  logic                  accept;
  logic                  load;
  logic                  starve;

  logic [WORD_WIDTH-1:0] staging_reg [NUM_SLOTS];
  logic [WORD_WIDTH-1:0] active_reg  [NUM_SLOTS];
  logic [WORD_WIDTH-1:0] active_next [NUM_SLOTS];
  logic [WORD_WIDTH-1:0] cur_word;
  logic [WORD_WIDTH-1:0] shifted;

  logic                  sdata_reg;
  logic                  sdata_next;
  logic                  frame_start_reg;
  logic                  underrun_reg;

  i2s_frame_timer #(
    .SLOT_WIDTH (SLOT_WIDTH),
    .NUM_SLOTS  (NUM_SLOTS)
  ) u_timer (
    .bclk     (bclk),
    .rst      (rst),
    .cnt      (frame_cnt),
    .lrclk    (lrclk),
    .boundary (boundary)
  );

  // Staging handshake and frame-boundary decision (uses the pre-edge fill).
  assign full     = (fill_reg == FW'(NUM_SLOTS));
  assign in_ready = ~full;
  assign in_slot  = fill_reg[SIW-1:0];
  assign accept   = in_valid & in_ready;
  assign load     = boundary & full;
  assign starve   = boundary & ~full;

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      fill_reg <= '0;
    end else if (load) begin
      fill_reg <= '0;
    end else if (accept) begin
      fill_reg <= fill_reg + FW'(1);
    end
  end

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      staging_reg <= '{default: '0};
    end else if (accept) begin
      staging_reg[fill_reg[SIW-1:0]] <= in_data;
    end
  end

  // Active frame after the coming edge; the serialiser reads it directly so
  // a freshly loaded frame is already on the wire in the c = 0 period.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_active
    assign active_next[gi] = load                             ? staging_reg[gi] :
                             (starve && (UNDERRUN_REPEAT == 0)) ? '0              :
                                                                  active_reg[gi];
  end

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      active_reg <= '{default: '0};
    end else begin
      active_reg <= active_next;
    end
  end

  // Slot and bit position of the period the coming edge enters.
  assign cnt_adv   = boundary ? '0 : frame_cnt + CW'(1);
  assign slot_adv  = SIW'(cnt_adv / CW'(SLOT_WIDTH));
  assign pos_adv   = PW'(cnt_adv % CW'(SLOT_WIDTH));
  assign in_window = (pos_adv >= PW'(D)) &&
                     ({1'b0, pos_adv} < (PW + 1)'(D + WORD_WIDTH));
  assign bit_off   = pos_adv - PW'(D);

  assign cur_word   = active_next[slot_adv];
  assign shifted    = cur_word << bit_off;
  assign sdata_next = in_window & shifted[WORD_WIDTH-1];

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      sdata_reg       <= 1'b0;
      frame_start_reg <= 1'b0;
      underrun_reg    <= 1'b0;
    end else begin
      sdata_reg       <= sdata_next;
      frame_start_reg <= load;
      underrun_reg    <= starve;
    end
  end

  assign sdata       = sdata_reg;
  assign frame_start = frame_start_reg;
  assign underrun    = underrun_reg;

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Bench for i2s_tdm_tx: a stereo I2S instance and a 4-slot left-justified
// repeat-on-underrun instance, both compared every bit period to a frame-level model.
module tb_i2s_tdm_tx;

  localparam int FRAME = 64;  // both instances: 2x32 and 4x16

  logic        bclk = 1'b0;
  logic        rst;
  logic [23:0] data_a;
  logic        valid_a, ready_a, lr_a, sd_a, fs_a, ur_a;
  logic [0:0]  slot_a;
  logic [15:0] data_b;
  logic        valid_b, ready_b, lr_b, sd_b, fs_b, ur_b;
  logic [1:0]  slot_b;

  always #5 bclk = ~bclk;

  i2s_tdm_tx u_a (
    .bclk        (bclk),
    .rst         (rst),
    .in_data     (data_a),
    .in_valid    (valid_a),
    .in_ready    (ready_a),
    .in_slot     (slot_a),
    .lrclk       (lr_a),
    .sdata       (sd_a),
    .frame_start (fs_a),
    .underrun    (ur_a)
  );

  i2s_tdm_tx #(
    .WORD_WIDTH      (16),
    .SLOT_WIDTH      (16),
    .NUM_SLOTS       (4),
    .MODE            (1),
    .UNDERRUN_REPEAT (1)
  ) u_b (
    .bclk        (bclk),
    .rst         (rst),
    .in_data     (data_b),
    .in_valid    (valid_b),
    .in_ready    (ready_b),
    .in_slot     (slot_b),
    .lrclk       (lr_b),
    .sdata       (sd_b),
    .frame_start (fs_b),
    .underrun    (ur_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check_val(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Per-instance configuration (index 0 = u_a, 1 = u_b).
  function automatic int ww(input int k);  return (k == 0) ? 24 : 16; endfunction
  function automatic int sw(input int k);  return (k == 0) ? 32 : 16; endfunction
  function automatic int ns(input int k);  return (k == 0) ? 2 : 4;   endfunction
  function automatic int dd(input int k);  return (k == 0) ? 1 : 0;   endfunction
  function automatic int rep(input int k); return k;                  endfunction

  // Frame-level reference: frame position, staged words, active frame.
  int m_cnt = 0;
  int fill [2];
  int stg  [2][4];
  int act  [2][4];
  bit fs_exp [2];
  bit ur_exp [2];

  always @(posedge bclk or posedge rst) begin
    if (rst) begin
      m_cnt = 0;
      for (int k = 0; k < 2; k++) begin
        fill[k] = 0;
        fs_exp[k] = 1'b0;
        ur_exp[k] = 1'b0;
        for (int i = 0; i < 4; i++) act[k][i] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit take;
        int word;
        if (k == 0) begin
          take = valid_a;
          word = int'(data_a);
        end else begin
          take = valid_b;
          word = int'(data_b);
        end
        take = take && (fill[k] < ns(k));
        fs_exp[k] = 1'b0;
        ur_exp[k] = 1'b0;
        if (m_cnt == FRAME - 1) begin
          if (fill[k] == ns(k)) begin
            for (int i = 0; i < 4; i++) act[k][i] = stg[k][i];
            fill[k] = 0;
            fs_exp[k] = 1'b1;
          end else begin
            ur_exp[k] = 1'b1;
            if (rep(k) == 0) for (int i = 0; i < 4; i++) act[k][i] = 0;
          end
        end
        if (take) begin
          stg[k][fill[k]] = word;
          fill[k] = fill[k] + 1;
        end
      end
      m_cnt = (m_cnt + 1) % FRAME;
    end
  end

  function automatic int exp_sd(input int k, input int n);
    int s;
    int p;
    s = n / sw(k);
    p = n % sw(k);
    if (p >= dd(k) && p < dd(k) + ww(k))
      return (act[k][s] >> (ww(k) - 1 - (p - dd(k)))) & 1;
    return 0;
  endfunction

  // Continuous comparison of every output against the model.
  always @(negedge bclk) begin
    if (chk_en && !rst) begin
      check_val($sformatf("A.lrclk@c%0d", m_cnt), int'(lr_a), int'(m_cnt >= FRAME / 2));
      check_val($sformatf("A.sdata@c%0d", m_cnt), int'(sd_a), exp_sd(0, m_cnt));
      check_val($sformatf("A.in_ready@c%0d", m_cnt), int'(ready_a), int'(fill[0] < 2));
      check_val($sformatf("A.in_slot@c%0d", m_cnt), int'(slot_a), fill[0] % 2);
      check_val($sformatf("A.frame_start@c%0d", m_cnt), int'(fs_a), int'(fs_exp[0]));
      check_val($sformatf("A.underrun@c%0d", m_cnt), int'(ur_a), int'(ur_exp[0]));
      check_val($sformatf("B.lrclk@c%0d", m_cnt), int'(lr_b), int'(m_cnt >= FRAME / 2));
      check_val($sformatf("B.sdata@c%0d", m_cnt), int'(sd_b), exp_sd(1, m_cnt));
      check_val($sformatf("B.in_ready@c%0d", m_cnt), int'(ready_b), int'(fill[1] < 4));
      check_val($sformatf("B.in_slot@c%0d", m_cnt), int'(slot_b), fill[1] % 4);
      check_val($sformatf("B.frame_start@c%0d", m_cnt), int'(fs_b), int'(fs_exp[1]));
      check_val($sformatf("B.underrun@c%0d", m_cnt), int'(ur_b), int'(ur_exp[1]));
    end
  end

  // Advance to the next bit period whose frame position is n (at least one period).
  task automatic wait_cnt(input int n);
    int guard;
    guard = 0;
    do begin
      @(negedge bclk);
      guard++;
    end while (m_cnt != n && guard < 4 * FRAME);
    check_val($sformatf("wait_cnt_%0d", n), m_cnt, n);
  endtask

  task automatic put_a(input logic [23:0] w);
    valid_a = 1'b1;
    data_a  = w;
    @(negedge bclk);
    valid_a = 1'b0;
  endtask

  logic [23:0] wa [2] = '{24'h800001, 24'h7FFFFE};
  logic [15:0] wb [4] = '{16'hA5A5, 16'h0001, 16'h8000, 16'hFFFF};

  initial begin
    rst = 1'b1;
    valid_a = 1'b0; data_a = '0;
    valid_b = 1'b0; data_b = '0;
    repeat (3) @(negedge bclk);
    check_val("reset.A.lrclk", int'(lr_a), 0);
    check_val("reset.A.sdata", int'(sd_a), 0);
    check_val("reset.A.in_ready", int'(ready_a), 1);
    check_val("reset.B.in_slot", int'(slot_b), 0);
    check_val("reset.B.frame_start", int'(fs_b), 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Full frames for both instances, staged from c = 0.
    for (int i = 0; i < 4; i++) begin
      valid_a = (i < 2);
      data_a  = wa[i % 2];
      valid_b = 1'b1;
      data_b  = wb[i];
      @(negedge bclk);
    end
    valid_a = 1'b0;
    valid_b = 1'b0;

    wait_cnt(0);
    check_val("f1.A.frame_start", int'(fs_a), 1);
    check_val("f1.B.frame_start", int'(fs_b), 1);
    check_val("f1.A.sdata.c0", int'(sd_a), 0);
    check_val("f1.B.msb0", int'(sd_b), 1);
    wait_cnt(1);  check_val("f1.A.msb_left", int'(sd_a), 1);
    wait_cnt(2);  check_val("f1.A.bit22_left", int'(sd_a), 0);
    wait_cnt(24); check_val("f1.A.lsb_left", int'(sd_a), 1);
    wait_cnt(25); check_val("f1.A.pad25", int'(sd_a), 0);
    wait_cnt(31);
    check_val("f1.A.lrclk31", int'(lr_a), 0);
    check_val("f1.B.lsb_slot1", int'(sd_b), 1);
    wait_cnt(32);
    check_val("f1.A.lrclk32", int'(lr_a), 1);
    check_val("f1.B.lrclk32", int'(lr_b), 1);
    check_val("f1.B.msb2", int'(sd_b), 1);
    wait_cnt(33); check_val("f1.A.msb_right", int'(sd_a), 0);
    wait_cnt(34); check_val("f1.A.bit22_right", int'(sd_a), 1);
    put_a(24'h400000);  // only one word before the next boundary
    wait_cnt(48); check_val("f1.B.msb3", int'(sd_b), 1);

    wait_cnt(0);
    check_val("f2.A.underrun", int'(ur_a), 1);
    check_val("f2.A.frame_start", int'(fs_a), 0);
    check_val("f2.A.in_slot", int'(slot_a), 1);
    check_val("f2.A.in_ready", int'(ready_a), 1);
    check_val("f2.B.underrun", int'(ur_b), 1);
    check_val("f2.B.repeat_msb0", int'(sd_b), 1);
    wait_cnt(1); check_val("f2.A.zero_msb", int'(sd_a), 0);
    wait_cnt(5); put_a(24'hC00000);
    wait_cnt(48); check_val("f2.B.repeat_msb3", int'(sd_b), 1);

    wait_cnt(0);
    check_val("f3.A.frame_start", int'(fs_a), 1);
    check_val("f3.B.underrun", int'(ur_b), 1);
    wait_cnt(2);  check_val("f3.A.bit22_left", int'(sd_a), 1);
    wait_cnt(33); check_val("f3.A.msb_right", int'(sd_a), 1);
    wait_cnt(40); put_a(24'h123456);
    wait_cnt(FRAME - 1);
    put_a(24'h654321);  // accepted on the boundary edge itself
    check_val("f4.A.underrun", int'(ur_a), 1);
    check_val("f4.A.frame_start", int'(fs_a), 0);
    check_val("f4.A.in_ready", int'(ready_a), 0);
    check_val("f4.B.underrun", int'(ur_b), 1);
    wait_cnt(20); check_val("f4.A.in_ready_mid", int'(ready_a), 0);
    wait_cnt(0);
    check_val("f5.A.frame_start", int'(fs_a), 1);
    check_val("f5.A.in_ready", int'(ready_a), 1);
    check_val("f5.A.in_slot", int'(slot_a), 0);

    // Random traffic: a mix of complete frames and underruns.
    repeat (40 * FRAME) begin
      valid_a = ($urandom_range(0, 39) == 0);
      data_a  = 24'($urandom);
      valid_b = ($urandom_range(0, 15) == 0);
      data_b  = 16'($urandom);
      @(negedge bclk);
    end
    valid_a = 1'b0;
    valid_b = 1'b0;

    // Asynchronous reset mid-frame with a partial stage.
    wait_cnt(0);
    if (fill[0] == 0) put_a(24'hABCDEF);
    wait_cnt(40);
    #2 rst = 1'b1;
    #1;
    check_val("arst.A.lrclk", int'(lr_a), 0);
    check_val("arst.A.sdata", int'(sd_a), 0);
    check_val("arst.A.in_ready", int'(ready_a), 1);
    check_val("arst.A.in_slot", int'(slot_a), 0);
    check_val("arst.B.lrclk", int'(lr_b), 0);
    check_val("arst.B.sdata", int'(sd_b), 0);
    repeat (3) @(negedge bclk);
    rst = 1'b0;
    #1;
    check_val("post.A.lrclk", int'(lr_a), 0);
    check_val("post.A.in_slot", int'(slot_a), 0);
    wait_cnt(0);
    check_val("post.A.underrun", int'(ur_a), 1);
    check_val("post.B.underrun", int'(ur_b), 1);
    wait_cnt(0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2s_tdm_tx.md
Name: i2s_tdm_tx

Overview:
- Parametrised multi-slot serial audio transmitter; successor to the mono-to-stereo I2S transmitter.
- Generates its own word-select (lrclk) from bclk and serialises NUM_SLOTS words per frame, in I2S (one-bit delay) or left-justified mode.
- Takes samples through a valid/ready stream into a double-buffered frame store, with defined underrun handling.
- Sits between the DSP output stage and the DAC (PCM5102 for stereo, TDM codecs for more than two slots).

Parameters:
- WORD_WIDTH, 24, sample bits per slot.
- SLOT_WIDTH, 32, bclk periods per slot.
- NUM_SLOTS, 2, slots per frame; even, at least 2.
- MODE, 0, 0 = I2S (MSB one bclk after slot start), 1 = left-justified (MSB at slot start).
- UNDERRUN_REPEAT, 0, 0 = transmit zeros on underrun, 1 = retransmit previous frame.

Ports:
- bclk  in  1  bit clock; sole clock, all logic on posedge.
- rst  in  1  asynchronous reset, active high.
- in_data  in  WORD_WIDTH  signed sample for slot in_slot.
- in_valid  in  1  in_data valid.
- in_ready  out  1  staging buffer can accept a word.
- in_slot  out  clog2(NUM_SLOTS)  slot index the next accepted word fills.
- lrclk  out  1  word select; low for the first half of the frame, high for the second.
- sdata  out  1  serial data to DAC.
- frame_start  out  1  one-cycle pulse when a complete staged frame is loaded.
- underrun  out  1  one-cycle pulse when a frame boundary finds staging incomplete.

Behaviour:
- Constraints: SLOT_WIDTH >= WORD_WIDTH + MODE==0 ? 1 : 0; violation is an elaboration error. FRAME = NUM_SLOTS*SLOT_WIDTH.
- Frame counter c runs 0..FRAME-1 and wraps to 0. Slot index s = c / SLOT_WIDTH; slot position p = c mod SLOT_WIDTH.
- lrclk, sdata and c are all registered and update on the same edge. During the bclk period in which c holds value n:
  - lrclk = (n >= FRAME/2).
  - sdata = active[s] bit (WORD_WIDTH-1-(p-D)) when D <= p < D+WORD_WIDTH, else 0. D = 1 for MODE 0, D = 0 for MODE 1.
  - Padding bits are zeros; the MSB goes first.
- Staging store:
  - Holds NUM_SLOTS words plus a fill count f (0..NUM_SLOTS).
  - in_ready = (f < NUM_SLOTS), combinational from f. in_slot = f.
  - Accept occurs when in_valid && in_ready: staging[f] <= in_data, f <= f+1.
- Frame boundary is the edge on which c goes FRAME-1 -> 0. The decision uses the pre-edge value of f:
  - If f == NUM_SLOTS: active <= staging, f <= 0, frame_start = 1 for one cycle.
  - Otherwise: underrun = 1 for one cycle; partial staging contents and f are kept. Active becomes all zeros (UNDERRUN_REPEAT=0) or stays unchanged (UNDERRUN_REPEAT=1).
  - The new active frame's first bit appears in the period where c = 0.
- Simultaneous events:
  - An accept that completes staging on the boundary edge itself counts for the next boundary, not the current one.
  - Accept and load never coincide on the same staging entry, because in_ready is low when f == NUM_SLOTS.
- Latency: a frame fully staged before boundary k is output during the frame that begins at k. From its last accepted word to its own MSB, latency is at most FRAME+D bclk periods.
- Reset (asserted at any time, including mid-frame):
  - c = 0, lrclk = 0, sdata = 0, frame_start = 0, underrun = 0.
  - active and staging are all zeros, f = 0, so in_ready = 1 and in_slot = 0.
  - Any partial frame is discarded.
  - After deassertion, the first frame starts at c = 0 with lrclk low; the first boundary at c = FRAME-1 underruns unless NUM_SLOTS words were accepted.

Decomposition:
- Shared package i2s_pkg:
  - Mode constants I2S_MODE_PHILIPS = 0, I2S_MODE_LEFT_JUST = 1.
  - Helper function for counter width clog2(FRAME).
- Sub-module i2s_frame_timer (bclk, rst -> c, lrclk, boundary strobe), reusable by a future multi-slot receiver.
- Staging/active buffers and the serialiser stay in i2s_tdm_tx.

Test Plan:
- Defaults; after reset write 0x800001 then 0x7FFFFE before first boundary -> frame_start at first wrap. Left slot: sdata 0 at c=0, bits 1,0..0,1 at c=1..24, zeros c=25..31. Right slot: 0x7FFFFE at c=33..56. lrclk rises entering c=32.
- MODE=1, NUM_SLOTS=4, WORD_WIDTH=16, SLOT_WIDTH=16; words 0xA5A5, 0x0001, 0x8000, 0xFFFF -> MSB of each at c=0,16,32,48. lrclk high for c=32..63.
- Only 1 of 2 words written before boundary -> underrun pulse, sdata all zero for the frame, f stays 1, in_slot=1. Second word, then next boundary -> frame_start with both words.
- UNDERRUN_REPEAT=1; one full frame loaded, then no writes -> underrun every frame, the same bit pattern repeated each frame.
- Last word accepted exactly on the c=FRAME-1 edge -> underrun at that boundary, frame_start at the following one. in_ready low for the intervening frame.
- Assert rst at c=40 with f=1 -> all outputs 0 asynchronously; after release lrclk=0 at c=0, in_ready=1, in_slot=0, no stale data emitted.
